// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the UART receive frame controller.
//   - frame_state_e : frame parser FSM encoding
//   - ERR_*         : error cause codes reported on err_code with frame_done
//   - SYNC_BYTE_DEFAULT : default frame start marker
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_OPC  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4
  } frame_state_e;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE    = 3'd0;
  localparam err_code_t ERR_LEN_BAD = 3'd1;
  localparam err_code_t ERR_CHK_BAD = 3'd2;
  localparam err_code_t ERR_TIMEOUT = 3'd3;
  localparam err_code_t ERR_BREAK   = 3'd4;
  localparam err_code_t ERR_OVERRUN = 3'd5;
  localparam err_code_t ERR_ABORT   = 3'd6;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_word_packer.sv
// uart_word_packer: packs payload bytes big-endian into WORD_BYTES-wide words
// and presents them on a valid/ready output. WORD_BYTES must be >= 2.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clear            : drop any partial/pending word (frame aborted or not in payload)
//   byte_valid/data  : incoming payload byte
//   hold             : keep an assembled word hidden (command header still pending)
//   word_ready       : consumer accepts the word
//   word_valid/data  : assembled word output
//   word_loaded      : pulse when a new word enters the output register
//   overrun          : a byte arrived while a completed word could not be released
module uart_word_packer #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  input  logic                    hold,
  input  logic                    word_ready,
  output logic                    word_valid,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_loaded,
  output logic                    overrun
);

  localparam int SH_W  = 8 * (WORD_BYTES - 1);
  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SH_W-1:0]         shift_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    full_q;
  logic [8*WORD_BYTES-1:0] shift_nxt;
  logic                    accept;
  logic                    take;

  assign shift_nxt   = {shift_q, byte_data};
  assign word_valid  = full_q && !hold;
  assign accept      = word_valid && word_ready;
  // A word released in the same cycle frees the output register for this byte.
  assign overrun     = byte_valid && full_q && !accept;
  assign take        = byte_valid && !overrun;
  assign word_loaded = take && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      word_data <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      if (accept) full_q <= 1'b0;
      if (take) begin
        if (cnt_q == CNT_LAST) begin
          word_data <= shift_nxt;
          full_q    <= 1'b1;
          cnt_q     <= '0;
        end else begin
          shift_q <= shift_nxt[SH_W-1:0];
          cnt_q   <= cnt_q + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: receive-side frame parser behind uart_rx.
// Frame: SYNC, OPCODE, LEN, LEN*WORD_BYTES payload bytes, CHK (XOR of OPCODE, LEN, payload).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   en / uart_rx_en        : controller enable, registered copy driven to uart_rx
//   uart_rx_valid/break/data : byte and break strobes from uart_rx
//   cmd_valid/ready, cmd_opcode, cmd_words : header handshake
//   word_valid/ready, word_data, word_last : payload word stream
//   frame_done, frame_err, err_code        : one-cycle end-of-frame report
//
// state   | meaning
// HUNT    | discard bytes until SYNC_BYTE
// OPC     | next byte is the opcode, seeds checksum
// LEN     | next byte is word count, range checked
// PAY     | payload bytes packed into words, words handed out
// CHK     | next byte compared against running checksum
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         WORD_BYTES     = 4,
  parameter int         MAX_WORDS      = 64,
  parameter int         TIMEOUT_CYCLES = 500_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  output logic                    uart_rx_en,
  input  logic                    uart_rx_valid,
  input  logic                    uart_rx_break,
  input  logic [7:0]              uart_rx_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_opcode,
  output logic [7:0]              cmd_words,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_last,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [2:0]              err_code
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [7:0]       MAX_LEN  = 8'(MAX_WORDS);

  frame_state_e     state_q, state_d;
  logic [7:0]       chk_q;
  logic [7:0]       wcnt_q;
  logic [TMR_W-1:0] tmr_q;
  err_code_t        err_d;
  logic             ok_d;
  logic             cmd_set;
  logic             byte_in;
  logic             pay_byte;
  logic             chk_match;
  logic             last_acc;
  logic             tmr_tc;
  logic             pk_clear;
  logic             pk_loaded;
  logic             pk_ovr;

  // The byte accompanying a break strobe is never data.
  assign byte_in   = uart_rx_valid && !uart_rx_break;
  assign pay_byte  = byte_in && (state_q == ST_PAY);
  assign chk_match = (uart_rx_data == chk_q);
  assign word_last = word_valid && (wcnt_q == cmd_words);
  assign last_acc  = word_valid && word_ready && word_last;
  // Terminal count: this edge completes TIMEOUT_CYCLES clocks since the last byte.
  assign tmr_tc    = (tmr_q == TMR_ONE);
  assign pk_clear  = (state_q != ST_PAY) || (err_d != ERR_NONE);

  uart_word_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (pk_clear),
    .byte_valid  (pay_byte),
    .byte_data   (uart_rx_data),
    .hold        (cmd_valid),
    .word_ready  (word_ready),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_loaded (pk_loaded),
    .overrun     (pk_ovr)
  );

  always_comb begin
    state_d = state_q;
    err_d   = ERR_NONE;
    ok_d    = 1'b0;
    cmd_set = 1'b0;
    if (state_q == ST_HUNT) begin
      if (en && byte_in && (uart_rx_data == SYNC_BYTE)) state_d = ST_OPC;
    end else if (uart_rx_break) begin
      err_d = ERR_BREAK;
    end else if (tmr_tc) begin
      err_d = ERR_TIMEOUT;
    end else if (!en) begin
      err_d = ERR_ABORT;
    end else begin
      case (state_q)
        ST_OPC: if (byte_in) state_d = ST_LEN;
        ST_LEN: begin
          if (byte_in) begin
            if ((uart_rx_data == 8'd0) || (uart_rx_data > MAX_LEN)) begin
              err_d = ERR_LEN_BAD;
            end else begin
              cmd_set = 1'b1;
              state_d = ST_PAY;
            end
          end
        end
        ST_PAY: begin
          if (pk_ovr) begin
            err_d = ERR_OVERRUN;
          end else if (last_acc) begin
            // CHK byte can land on the same edge the last word is taken.
            if (byte_in) begin
              if (chk_match) ok_d = 1'b1;
              else           err_d = ERR_CHK_BAD;
            end else begin
              state_d = ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (byte_in) begin
            if (chk_match) ok_d = 1'b1;
            else           err_d = ERR_CHK_BAD;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if ((err_d != ERR_NONE) || ok_d) state_d = ST_HUNT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      uart_rx_en <= 1'b0;
      chk_q      <= '0;
      wcnt_q     <= '0;
      tmr_q      <= '0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= '0;
      cmd_words  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      uart_rx_en <= en;
      frame_done <= (err_d != ERR_NONE) || ok_d;
      frame_err  <= (err_d != ERR_NONE);
      err_code   <= err_d;

      if ((state_q == ST_HUNT) || uart_rx_valid) tmr_q <= TMR_LOAD;
      else if (tmr_q != '0)                      tmr_q <= tmr_q - TMR_ONE;

      if ((state_q == ST_OPC) && (state_d == ST_LEN)) begin
        cmd_opcode <= uart_rx_data;
        chk_q      <= uart_rx_data;
      end else if (byte_in && ((state_q == ST_LEN) || (state_q == ST_PAY))) begin
        chk_q <= chk_q ^ uart_rx_data;
      end

      if (cmd_set) begin
        cmd_words <= uart_rx_data;
        wcnt_q    <= '0;
      end else if (pk_loaded) begin
        wcnt_q <= wcnt_q + 8'd1;
      end

      if (err_d != ERR_NONE) cmd_valid <= 1'b0;
      else if (cmd_set)      cmd_valid <= 1'b1;
      else if (cmd_ready)    cmd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;

  localparam int WB   = 4;
  localparam int MAXW = 64;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        reset, en, uart_rx_en, uart_rx_valid, uart_rx_break;
  logic [7:0]  uart_rx_data;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_opcode, cmd_words;
  logic        word_valid, word_ready;
  logic [31:0] word_data;
  logic        word_last, frame_done, frame_err;
  logic [2:0]  err_code;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random ready, 2: word_ready low

  logic [15:0] cmd_q[$];
  logic [32:0] word_q[$];
  logic [3:0]  done_q[$];
  logic [7:0]  tx_pay[$];

  always #5 clk = ~clk;

  uart_frame_ctrl #(.WORD_BYTES(WB), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .uart_rx_en(uart_rx_en),
    .uart_rx_valid(uart_rx_valid), .uart_rx_break(uart_rx_break), .uart_rx_data(uart_rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_words(cmd_words),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data), .word_last(word_last),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready)   cmd_q.push_back({cmd_opcode, cmd_words});
      if (word_valid && word_ready) word_q.push_back({word_last, word_data});
      if (frame_done)               done_q.push_back({frame_err, err_code});
    end
  end

  initial begin : rdy_gen
    int ws, cs;
    ws = 0; cs = 0;
    word_ready = 1'b0;
    cmd_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin
          word_ready = (ws >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
          cmd_ready  = (cs >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
          ws = word_ready ? 0 : ws + 1;
          cs = cmd_ready ? 0 : cs + 1;
        end
        2: begin word_ready = 1'b0; cmd_ready = 1'b1; end
        default: begin word_ready = 1'b1; cmd_ready = 1'b1; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    uart_rx_valid = 1'b1; uart_rx_data = b;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_break();
    @(posedge clk); #1;
    uart_rx_valid = 1'b1; uart_rx_break = 1'b1; uart_rx_data = 8'h00;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0; uart_rx_break = 1'b0;
  endtask

  task automatic clear_q();
    cmd_q.delete(); word_q.delete(); done_q.delete();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(negedge clk); n++;
    end
  endtask

  // Reference: a frame yields one header, LEN big-endian words (last flagged)
  // and one done report whose code depends only on LEN range and checksum.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] len, input bit corrupt,
                           input int ngarb, input int gap, input string tag);
    logic [7:0]  chk_b;
    logic [31:0] w;
    logic [3:0]  exp_done;
    bit          len_ok;
    int          nw;
    clear_q();
    for (int i = 0; i < ngarb; i++) begin
      logic [7:0] g;
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, gap);
    end
    chk({tag, "_garbage_quiet"}, 64'(done_q.size()), 64'(0));
    len_ok = (len >= 8'd1) && (int'(len) <= MAXW);
    send_byte(8'hA5, gap);
    send_byte(op, gap);
    send_byte(len, gap);
    if (len_ok) begin
      chk_b = op ^ len;
      foreach (tx_pay[i]) chk_b = chk_b ^ tx_pay[i];
      foreach (tx_pay[i]) send_byte(tx_pay[i], gap);
      if (corrupt) chk_b = chk_b ^ 8'($urandom_range(1, 255));
      send_byte(chk_b, gap);
    end
    wait_done(50);
    repeat (2) @(negedge clk);
    exp_done = !len_ok ? 4'b1001 : (corrupt ? 4'b1010 : 4'b0000);
    nw = len_ok ? int'(len) : 0;
    chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'(1));
    if (done_q.size() > 0) chk({tag, "_done_code"}, 64'(done_q[0]), 64'(exp_done));
    chk({tag, "_cmd_cnt"}, 64'(cmd_q.size()), 64'(len_ok ? 1 : 0));
    if (len_ok && cmd_q.size() > 0) chk({tag, "_cmd"}, 64'(cmd_q[0]), 64'({op, len}));
    chk({tag, "_word_cnt"}, 64'(word_q.size()), 64'(nw));
    for (int k = 0; k < nw && k < word_q.size(); k++) begin
      w = '0;
      for (int j = 0; j < WB; j++) w = {w[23:0], tx_pay[WB*k+j]};
      chk({tag, "_word"}, 64'(word_q[k]), 64'({(k == nw - 1), w}));
    end
  endtask

  initial begin
    logic [7:0] c;
    int n;
    reset = 1'b1; en = 1'b1;
    uart_rx_valid = 1'b0; uart_rx_break = 1'b0; uart_rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 64'({uart_rx_en, cmd_valid, cmd_opcode, cmd_words, word_valid, word_data,
                              word_last, frame_done, frame_err, err_code}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rx_en_follows_en", 64'(uart_rx_en), 64'(1));

    // Reference good frame with latency checks.
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h01, 0);
    chk("cmd_valid_lat", 64'(cmd_valid), 64'(1));
    chk("cmd_fields", 64'({cmd_opcode, cmd_words}), 64'(16'h0701));
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    chk("word_valid_lat", 64'(word_valid), 64'(1));
    chk("word_out", 64'({word_last, word_data}), 64'({1'b1, 32'h11223344}));
    c = 8'h07 ^ 8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
    send_byte(c, 0);
    chk("good_done", 64'({frame_done, frame_err, err_code}), 64'({1'b1, 1'b0, 3'd0}));
    @(posedge clk); #1;
    chk("done_is_pulse", 64'(frame_done), 64'(0));

    // Same frame, CHK = 00.
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h00, 0);
    chk("bad_chk_done", 64'({frame_done, frame_err, err_code}), 64'({1'b1, 1'b1, 3'd2}));
    repeat (2) @(negedge clk);
    chk("bad_chk_word", 64'(word_q.size() > 0 ? word_q[0] : 33'h0), 64'({1'b1, 32'h11223344}));
    tx_pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h07, 8'h01, 1'b0, 0, 1, "after_bad");

    // LEN bounds.
    tx_pay.delete();
    run_frame(8'h33, 8'd0, 1'b0, 0, 1, "len0");
    run_frame(8'h34, 8'(MAXW + 1), 1'b0, 0, 1, "len_max_plus1");
    tx_pay.delete();
    for (int i = 0; i < MAXW * WB; i++) tx_pay.push_back(8'($urandom_range(0, 255)));
    run_frame(8'h35, 8'(MAXW), 1'b0, 0, 1, "len_max");

    // Overrun: word_ready held low.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h02, 0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
    chk("ovr_not_early", 64'({frame_done, word_valid}), 64'(2'b01));
    send_byte(8'h05, 0);
    chk("ovr_done", 64'({frame_done, frame_err, err_code, word_valid}), 64'({1'b1, 1'b1, 3'd5, 1'b0}));
    for (int i = 6; i <= 8; i++) send_byte(8'(i), 0);
    repeat (3) @(negedge clk);
    chk("ovr_single_report", 64'({done_q.size(), word_q.size()}), 64'({32'd1, 32'd0}));
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    // Inter-byte timeout.
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    n = 0;
    while (!frame_done && n < 3 * TO) begin
      @(posedge clk); #1; n++;
    end
    chk("timeout_cycles", 64'(n), 64'(TO));
    chk("timeout_code", 64'({frame_err, err_code}), 64'({1'b1, 3'd3}));

    // Break mid-frame, then break while hunting.
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    send_break();
    chk("break_code", 64'({frame_done, frame_err, err_code}), 64'({1'b1, 1'b1, 3'd4}));
    repeat (3) @(posedge clk);
    clear_q();
    send_break(); repeat (3) @(posedge clk); send_break();
    repeat (3) @(negedge clk);
    chk("break_in_hunt_ignored", 64'(done_q.size()), 64'(0));

    // Garbage before SYNC.
    clear_q();
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h5A, 1);
    repeat (3) @(negedge clk);
    chk("garbage_no_done", 64'(done_q.size()), 64'(0));
    tx_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(8'h42, 8'h01, 1'b0, 0, 1, "post_garbage");

    // Enable dropped mid-frame.
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0);
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_code", 64'({frame_done, frame_err, err_code}), 64'({1'b1, 1'b1, 3'd6}));
    chk("abort_rx_en", 64'(uart_rx_en), 64'(0));
    en = 1'b1;
    repeat (3) @(posedge clk);

    // Reset mid-frame.
    clear_q();
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h01, 0); send_byte(8'h11, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midframe_reset_outputs", 64'({uart_rx_en, cmd_valid, cmd_opcode, cmd_words, word_valid, word_data,
                                       word_last, frame_done, frame_err, err_code}), 64'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midframe_reset_silent", 64'(done_q.size()), 64'(0));

    // Randomized frames with random ready back-pressure.
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      logic [7:0] op, len;
      bit bad;
      op  = 8'($urandom_range(0, 255));
      len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(MAXW + 1, 255))
                                        : 8'($urandom_range(1, 4));
      bad = ($urandom_range(0, 3) == 0);
      tx_pay.delete();
      if (len <= 8'(MAXW))
        for (int i = 0; i < int'(len) * WB; i++) tx_pay.push_back(8'($urandom_range(0, 255)));
      run_frame(op, len, bad, int'($urandom_range(0, 2)), 3, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
